// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial front end: WIDTH-bit words in, MSB-first bits out on w.
// Optional even-parity trailer bit when SER_PARITY_EN is defined.
module seq_bit_serializer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             ser_en,
    output logic             w,
    output logic             w_valid,
    output logic             busy,
    output logic             word_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01
    } state_t;

`ifdef SER_PARITY_EN
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH);
`else
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [WIDTH-1:0] hbuf_q, hbuf_d;
    logic [CNT_W-1:0] bcnt_q, bcnt_d;
    logic             hfull_q, hfull_d;
    logic             done_q, done_d;
    logic             accept;
`ifdef SER_PARITY_EN
    logic             par_q, par_d;
`endif

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        hbuf_d  = hbuf_q;
        bcnt_d  = bcnt_q;
        hfull_d = hfull_q;
        done_d  = 1'b0;
        w       = 1'b0;
        w_valid = 1'b0;
        accept  = in_valid & ~hfull_q;
`ifdef SER_PARITY_EN
        par_d   = par_q;
`endif

        case (state_q)
            IDLE: begin
                if (hfull_q) begin
                    sreg_d  = hbuf_q;
                    hfull_d = 1'b0;
                    bcnt_d  = '0;
                    state_d = SHIFT;
`ifdef SER_PARITY_EN
                    par_d   = ^hbuf_q;
`endif
                end
            end
            SHIFT: begin
                w_valid = 1'b1;
                w       = sreg_q[WIDTH-1];
`ifdef SER_PARITY_EN
                // data bits are shifted out by now; emit the trailer
                if (bcnt_q == LAST) w = par_q;
`endif
                if (ser_en) begin
                    if (bcnt_q < LAST) begin
                        sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
                        bcnt_d = bcnt_q + CNT_W'(1);
                    end else begin
                        done_d = 1'b1;
                        if (hfull_q) begin
                            sreg_d  = hbuf_q;
                            hfull_d = 1'b0;
                            bcnt_d  = '0;
`ifdef SER_PARITY_EN
                            par_d   = ^hbuf_q;
`endif
                        end else begin
                            sreg_d  = '0;
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // accept never coincides with a load: hfull_q blocks it
        if (accept) begin
            hbuf_d  = in_data;
            hfull_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            hbuf_q  <= '0;
            bcnt_q  <= '0;
            hfull_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            hbuf_q  <= hbuf_d;
            bcnt_q  <= bcnt_d;
            hfull_q <= hfull_d;
            done_q  <= done_d;
        end
    end

`ifdef SER_PARITY_EN
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) par_q <= 1'b0;
        else        par_q <= par_d;
    end
`endif

    assign in_ready  = ~hfull_q;
    assign busy      = (state_q == SHIFT) | hfull_q;
    assign word_done = done_q;

endmodule
